// File: rtl/tilemap_scroll_feeder_pkg.sv
// tilemap_scroll_feeder_pkg: phase slot numbers, CPU map region bases and the
// shared source-select type for the scroll feeder.
package tilemap_scroll_feeder_pkg;

  // Pixel phases {4H,2H,1H} at which the tilemap generator samples each slot.
  localparam logic [2:0] PH_A_LO = 3'd1;
  localparam logic [2:0] PH_A_HI = 3'd3;
  localparam logic [2:0] PH_B_LO = 3'd5;
  localparam logic [2:0] PH_B_HI = 3'd7;
  localparam logic [2:0] PH_VS_B = 3'd3;
  localparam logic [2:0] PH_VS_A = 3'd7;

  // CPU map: hscroll tables occupy 0x000-0x3FF, vscroll A then B follow.
  localparam logic [10:0] CPU_VS_A_BASE = 11'h400;
  localparam logic [10:0] CPU_VS_B_BASE = 11'h440;
  localparam logic [10:0] CPU_MAP_END   = 11'h480;

  // Which storage feeds a registered output byte.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_HS,
    SRC_VS
  } src_e;

  // Byte view of a 9-bit global hscroll value: lo byte, or {7'b0, bit8}.
  function automatic logic [7:0] hs_byte(input logic [8:0] val, input logic hi);
    return hi ? {7'b0, val[8]} : val[7:0];
  endfunction

endpackage

// File: rtl/scroll_table_dpram.sv
// scroll_table_dpram: one write port, one registered read port, both gated by
// the pixel clock enable. A same-tick read of the written entry returns the
// old word.
module scroll_table_dpram #(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Registered read and write on the enabled tick.
  // NOTE: no reset on mem or rdata so the array maps onto block RAM; the
  // non-blocking pair reads the old word when raddr == waddr on a write tick.
  always_ff @(posedge clk) begin
    if (cen) begin
      rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/tilemap_scroll_feeder.sv
// tilemap_scroll_feeder: drives scroll bytes onto the tilemap generator's GFX
// data bus in fixed 8-pixel phase slots and hosts the CPU scroll tables.
// Build option ROWSCROLL_EN: per-line hscroll tables indexed by i_VLINE;
// without it hscroll comes from two global 9-bit registers.
module tilemap_scroll_feeder
  import tilemap_scroll_feeder_pkg::*;
#(
  parameter logic [8:0] HS_DEFAULT = 9'h01F,
  parameter int         VS_COLS    = 64
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST_n,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic        i_ABS_4H,
  input  logic        i_ABS_2H,
  input  logic        i_ABS_1H,
  input  logic        i_VCLK,
  input  logic [7:0]  i_VLINE,
  input  logic [5:0]  i_HCOL,
  input  logic [10:0] i_CPUADDR,
  input  logic [7:0]  i_CPUDIN,
  input  logic        i_CPUWR_n,
  output logic [7:0]  o_CPUDOUT,
  output logic [7:0]  o_GFXDATA,
  output logic        o_GFXDATA_OE
);

  localparam int VS_AW = $clog2(VS_COLS) + 1;

  logic             cen;
  logic             cpu_wr;
  logic [2:0]       next_phase;
  src_e             slot_src, cpu_src, slot_q, cpu_q;
  logic [1:0]       hs_region;
  logic             vs_layer;
  logic [VS_AW-1:0] vs_waddr;
  logic [7:0]       vs_slot_rd, vs_cpu_rd, hs_slot_rd, hs_cpu_rd;

  assign cen        = ~i_EMU_CLK6MPCEN_n;
  assign cpu_wr     = ~i_CPUWR_n;
  // Everything registered on this tick is sampled by the generator at the next phase.
  assign next_phase = {i_ABS_4H, i_ABS_2H, i_ABS_1H} + 3'd1;
  assign vs_waddr   = {i_CPUADDR >= CPU_VS_B_BASE, i_CPUADDR[5:0]};

  // Decode which slot (if any) the generator samples at the next phase.
  always_comb begin
    slot_src  = SRC_NONE;
    hs_region = 2'd0;
    vs_layer  = 1'b0;
    if (i_VCLK) begin
      case (next_phase)
        PH_A_LO: begin slot_src = SRC_HS; hs_region = 2'd0; end
        PH_A_HI: begin slot_src = SRC_HS; hs_region = 2'd1; end
        PH_B_LO: begin slot_src = SRC_HS; hs_region = 2'd2; end
        PH_B_HI: begin slot_src = SRC_HS; hs_region = 2'd3; end
        default: ;
      endcase
    end else if (next_phase == PH_VS_B) begin
      slot_src = SRC_VS;
      vs_layer = 1'b1;
    end else if (next_phase == PH_VS_A) begin
      slot_src = SRC_VS;
    end
  end

  // Decode the CPU address into the storage it selects.
  always_comb begin
    cpu_src = SRC_NONE;
    if (i_CPUADDR < CPU_VS_A_BASE)    cpu_src = SRC_HS;
    else if (i_CPUADDR < CPU_MAP_END) cpu_src = SRC_VS;
  end

  // Source selects for the bus slot and CPU readback, advanced on CEN ticks.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      slot_q <= SRC_NONE;
      cpu_q  <= SRC_NONE;
    end else if (cen) begin
      slot_q <= slot_src;
      cpu_q  <= cpu_src;
    end
  end

  // The slot port reads on every tick, so CPU readback uses a write-mirrored copy.
  scroll_table_dpram #(.AW(VS_AW), .DW(8)) u_vs_slot (
    .clk(i_EMU_MCLK), .cen(cen), .we(cpu_wr && cpu_src == SRC_VS),
    .waddr(vs_waddr), .wdata(i_CPUDIN), .raddr({vs_layer, i_HCOL}), .rdata(vs_slot_rd)
  );
  scroll_table_dpram #(.AW(VS_AW), .DW(8)) u_vs_cpu (
    .clk(i_EMU_MCLK), .cen(cen), .we(cpu_wr && cpu_src == SRC_VS),
    .waddr(vs_waddr), .wdata(i_CPUDIN), .raddr(vs_waddr), .rdata(vs_cpu_rd)
  );

`ifdef ROWSCROLL_EN
  // Global registers do not exist in this build.
  localparam logic [8:0] UNUSED_HS_DEFAULT = HS_DEFAULT;
  logic [7:0] hs_wdata;

  // Hi tables keep only bit0.
  assign hs_wdata = i_CPUADDR[8] ? {7'b0, i_CPUDIN[0]} : i_CPUDIN;

  scroll_table_dpram #(.AW(10), .DW(8)) u_hs_slot (
    .clk(i_EMU_MCLK), .cen(cen), .we(cpu_wr && cpu_src == SRC_HS),
    .waddr(i_CPUADDR[9:0]), .wdata(hs_wdata), .raddr({hs_region, i_VLINE}), .rdata(hs_slot_rd)
  );
  scroll_table_dpram #(.AW(10), .DW(8)) u_hs_cpu (
    .clk(i_EMU_MCLK), .cen(cen), .we(cpu_wr && cpu_src == SRC_HS),
    .waddr(i_CPUADDR[9:0]), .wdata(hs_wdata), .raddr(i_CPUADDR[9:0]), .rdata(hs_cpu_rd)
  );
`else
  logic [8:0] hs_a, hs_b;
  logic       unused_vline;

  // Line index has no meaning with global hscroll.
  assign unused_vline = ^i_VLINE;

  // Global hscroll registers with read-before-write slot and readback bytes.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      hs_a       <= HS_DEFAULT;
      hs_b       <= HS_DEFAULT;
      hs_slot_rd <= 8'h00;
      hs_cpu_rd  <= 8'h00;
    end else if (cen) begin
      hs_slot_rd <= hs_byte(hs_region[1] ? hs_b : hs_a, hs_region[0]);
      hs_cpu_rd  <= hs_byte(i_CPUADDR[9] ? hs_b : hs_a, i_CPUADDR[8]);
      if (cpu_wr && cpu_src == SRC_HS) begin
        case (i_CPUADDR[9:8])
          2'd0:    hs_a[7:0] <= i_CPUDIN;
          2'd1:    hs_a[8]   <= i_CPUDIN[0];
          2'd2:    hs_b[7:0] <= i_CPUDIN;
          default: hs_b[8]   <= i_CPUDIN[0];
        endcase
      end
    end
  end
`endif

  // Bus byte: zero with OE low outside scroll slots.
  always_comb begin
    o_GFXDATA    = 8'h00;
    o_GFXDATA_OE = 1'b0;
    case (slot_q)
      SRC_HS:  begin o_GFXDATA = hs_slot_rd; o_GFXDATA_OE = 1'b1; end
      SRC_VS:  begin o_GFXDATA = vs_slot_rd; o_GFXDATA_OE = 1'b1; end
      default: ;
    endcase
  end

  // CPU readback: unmapped addresses read as zero.
  always_comb begin
    o_CPUDOUT = 8'h00;
    case (cpu_q)
      SRC_HS:  o_CPUDOUT = hs_cpu_rd;
      SRC_VS:  o_CPUDOUT = vs_cpu_rd;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tilemap_scroll_feeder.sv
// tb_tilemap_scroll_feeder: scoreboard bench for tilemap_scroll_feeder with a
// table-level reference model. Honours ROWSCROLL_EN when defined.
module tb_tilemap_scroll_feeder;

`ifdef ROWSCROLL_EN
  localparam bit ROWSCROLL = 1'b1;
`else
  localparam bit ROWSCROLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen_n = 1'b1;
  logic [2:0]  ph_s = 3'd0;
  logic        vclk = 1'b0;
  logic [7:0]  vline = 8'd0;
  logic [5:0]  hcol = 6'd0;
  logic [10:0] addr = 11'd0;
  logic [7:0]  din = 8'd0;
  logic        wr_n = 1'b1;
  logic [7:0]  cpudout, gfxdata;
  logic        gfx_oe;

  always #5 clk = ~clk;

  tilemap_scroll_feeder dut (
    .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_ABS_4H(ph_s[2]), .i_ABS_2H(ph_s[1]), .i_ABS_1H(ph_s[0]),
    .i_VCLK(vclk), .i_VLINE(vline), .i_HCOL(hcol),
    .i_CPUADDR(addr), .i_CPUDIN(din), .i_CPUWR_n(wr_n),
    .o_CPUDOUT(cpudout), .o_GFXDATA(gfxdata), .o_GFXDATA_OE(gfx_oe)
  );

  int vectors = 0;
  int miscompares = 0;
  string cur_tag = "init";

  typedef struct {
    logic       oe;
    logic [7:0] data;
    bit         data_known;
    logic [7:0] cpu;
    bit         cpu_known;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: four hscroll tables (A lo, A hi, B lo, B hi), two vscroll tables.
  logic [7:0] m_hs [4][256];
  bit         m_hs_ok [4][256];
  logic [7:0] m_vs [2][64];
  bit         m_vs_ok [2][64];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Global hscroll collapses every line onto entry 0.
  function automatic int hs_line(input logic [7:0] line);
    return ROWSCROLL ? int'(line) : 0;
  endfunction

  function automatic void slot_model(input int p, input logic v, input logic [7:0] line,
                                     input logic [5:0] col, output logic oe,
                                     output logic [7:0] data, output bit known);
    int r = -1;
    oe = 1'b0; data = 8'h00; known = 1'b1;
    if (v) begin
      case (p) 1: r = 0; 3: r = 1; 5: r = 2; 7: r = 3; default: r = -1; endcase
      if (r >= 0) begin
        oe = 1'b1; data = m_hs[r][hs_line(line)]; known = m_hs_ok[r][hs_line(line)];
      end
    end else begin
      case (p) 3: r = 1; 7: r = 0; default: r = -1; endcase
      if (r >= 0) begin
        oe = 1'b1; data = m_vs[r][col]; known = m_vs_ok[r][col];
      end
    end
  endfunction

  function automatic void cpu_model(input logic [10:0] a, output logic [7:0] data, output bit known);
    data = 8'h00; known = 1'b1;
    if (a < 11'h400) begin
      data = m_hs[int'(a[9:8])][hs_line(a[7:0])]; known = m_hs_ok[int'(a[9:8])][hs_line(a[7:0])];
    end else if (a < 11'h480) begin
      data = m_vs[int'(a[6])][a[5:0]]; known = m_vs_ok[int'(a[6])][a[5:0]];
    end
  endfunction

  function automatic void model_write(input logic [10:0] a, input logic [7:0] d);
    if (a < 11'h400) begin
      m_hs[int'(a[9:8])][hs_line(a[7:0])]    = a[8] ? {7'b0, d[0]} : d;
      m_hs_ok[int'(a[9:8])][hs_line(a[7:0])] = 1'b1;
    end else if (a < 11'h480) begin
      m_vs[int'(a[6])][a[5:0]]    = d;
      m_vs_ok[int'(a[6])][a[5:0]] = 1'b1;
    end
  endfunction

  // Reset restores only the global registers (HS_DEFAULT = 9'h01F).
  function automatic void model_reset();
    if (!ROWSCROLL) begin
      m_hs[0][0] = 8'h1F; m_hs[1][0] = 8'h00; m_hs[2][0] = 8'h1F; m_hs[3][0] = 8'h00;
      for (int r = 0; r < 4; r++) m_hs_ok[r][0] = 1'b1;
    end
  endfunction

  // One CEN tick, preceded by 0-2 non-CEN cycles carrying junk (incl. write strobes).
  task automatic tick(input logic [2:0] ph, input logic v, input logic [7:0] line,
                      input logic [5:0] col, input logic wr, input logic [10:0] a,
                      input logic [7:0] d);
    exp_t e;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      cen_n = 1'b1; ph_s = 3'($urandom); vclk = 1'($urandom); vline = 8'($urandom);
      hcol = 6'($urandom); wr_n = 1'($urandom); addr = 11'($urandom); din = 8'($urandom);
    end
    @(negedge clk);
    cen_n = 1'b0; ph_s = ph; vclk = v; vline = line; hcol = col;
    wr_n = ~wr; addr = a; din = d;
    slot_model((int'(ph) + 1) % 8, v, line, col, e.oe, e.data, e.data_known);
    cpu_model(a, e.cpu, e.cpu_known);
    e.tag = cur_tag;
    exp_q.push_back(e);
    if (wr) model_write(a, d);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    tick(3'd1, 1'($urandom), 8'($urandom), 6'($urandom), 1'b1, a, d);
  endtask

  task automatic run_group(input logic v, input logic [7:0] line, input logic [5:0] col,
                           input logic [10:0] a);
    for (int q = 0; q < 8; q++) tick(3'(q), v, line, col, 1'b0, a, 8'h00);
  endtask

  // Monitor: one expectation per CEN tick, compared just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (!cen_n && rst_n) begin
        #1;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL scoreboard: DUT tick with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_oe"}, 16'(gfx_oe), 16'(e.oe));
          if (e.data_known) check({e.tag, "_gfx"}, 16'(gfxdata), 16'(e.data));
          if (e.cpu_known)  check({e.tag, "_cpu"}, 16'(cpudout), 16'(e.cpu));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic v;
    logic [7:0] line;
    for (int r = 0; r < 4; r++) for (int i = 0; i < 256; i++) m_hs_ok[r][i] = 1'b0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 64; i++) m_vs_ok[r][i] = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check("reset_gfx", 16'(gfxdata), 16'h0);
    check("reset_oe", 16'(gfx_oe), 16'h0);
    check("reset_cpu", 16'(cpudout), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults on a VCLK line.
    cur_tag = "t1_default_line";
    run_group(1'b1, 8'h00, 6'd0, 11'h000);

    // Give every table entry a known value.
    cur_tag = "preload";
    for (int i = 0; i < 128; i++) cpu_write(11'h400 + 11'(i), 8'($urandom));
    if (ROWSCROLL) for (int i = 0; i < 1024; i++) cpu_write(11'(i), 8'($urandom));

    cur_tag = "t2_hscroll";
    cpu_write(11'h012, 8'hA5); cpu_write(11'h112, 8'h01);
    cpu_write(11'h212, 8'h3C); cpu_write(11'h312, 8'h00);
    run_group(1'b1, 8'h12, 6'd0, 11'h112);

    cur_tag = "t3_vscroll";
    cpu_write(11'h405, 8'h77); cpu_write(11'h445, 8'h88);
    run_group(1'b0, 8'h00, 6'd5, 11'h445);

    // Same-tick write and slot fetch of A vscroll[9].
    cur_tag = "t4_collision";
    cpu_write(11'h409, 8'h10);
    for (int q = 0; q < 8; q++)
      tick(3'(q), 1'b0, 8'h00, 6'd9, q == 6, 11'h409, 8'h20);
    run_group(1'b0, 8'h00, 6'd9, 11'h409);

    cur_tag = "t5_col_wrap";
    cpu_write(11'h43F, 8'hEE); cpu_write(11'h400, 8'h11);
    run_group(1'b0, 8'h00, 6'd63, 11'h43F);
    run_group(1'b0, 8'h00, 6'd0, 11'h400);

    cur_tag = "hi_mask";
    cpu_write(11'h1AB, 8'hFE);
    cpu_write(11'h3C4, 8'hFF);
    run_group(1'b1, 8'hC4, 6'd0, 11'h3C4);
    cur_tag = "unmapped";
    cpu_write(11'h480, 8'h5A);
    cpu_write(11'h7FF, 8'hC3);
    run_group(1'b0, 8'h00, 6'd0, 11'h7FF);

    // Asynchronous reset while a slot is on the bus.
    cur_tag = "t6_reset";
    cpu_write(11'h000, 8'h5A);
    tick(3'd0, 1'b1, 8'h00, 6'd0, 1'b0, 11'h000, 8'h00);
    @(negedge clk);
    cen_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_gfx", 16'(gfxdata), 16'h0);
    check("t6_rst_oe", 16'(gfx_oe), 16'h0);
    check("t6_rst_cpu", 16'(cpudout), 16'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_release_oe", 16'(gfx_oe), 16'h0);
    for (int q = 1; q < 8; q++) tick(3'(q), 1'b1, 8'h00, 6'd0, 1'b0, 11'h000, 8'h00);

    // Random lines, columns, addresses and writes.
    cur_tag = "random";
    for (int g = 0; g < 60; g++) begin
      v = 1'($urandom);
      line = 8'($urandom);
      for (int q = 0; q < 8; q++)
        tick(3'(q), v, line, 6'($urandom), $urandom_range(0, 3) == 0,
             ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 11'h47F)),
             8'($urandom));
    end

    @(negedge clk);
    cen_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
